// File: rtl/bf_pkg.sv
// bf_pkg: shared constants for the brainhack program loader.
//   - 3-bit opcode encoding written into program memory
//   - abort cause codes reported on o_error_code
//   - loader FSM state encodings
//   - ASCII values of the instruction characters
package bf_pkg;

    localparam logic [2:0] OP_HALT  = 3'b000;
    localparam logic [2:0] OP_INC   = 3'b011;
    localparam logic [2:0] OP_DEC   = 3'b010;
    localparam logic [2:0] OP_RIGHT = 3'b101;
    localparam logic [2:0] OP_LEFT  = 3'b100;
    localparam logic [2:0] OP_OPEN  = 3'b111;
    localparam logic [2:0] OP_CLOSE = 3'b110;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_UNMATCHED = 3'd1;
    localparam logic [2:0] ERR_DEPTH     = 3'd2;
    localparam logic [2:0] ERR_LENGTH    = 3'd3;
    localparam logic [2:0] ERR_UNCLOSED  = 3'd4;

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_TERM = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    localparam logic [7:0] CH_INC   = 8'h2B;  // '+'
    localparam logic [7:0] CH_DEC   = 8'h2D;  // '-'
    localparam logic [7:0] CH_RIGHT = 8'h3E;  // '>'
    localparam logic [7:0] CH_LEFT  = 8'h3C;  // '<'
    localparam logic [7:0] CH_OPEN  = 8'h5B;  // '['
    localparam logic [7:0] CH_CLOSE = 8'h5D;  // ']'

endpackage

// File: rtl/bf_char_encoder.sv
// bf_char_encoder: combinational ASCII to opcode translation.
//   byte_data : source character
//   is_op     : character is one of the six instruction characters
//   opcode    : encoded opcode (OP_HALT when is_op is low)
module bf_char_encoder
    import bf_pkg::*;
(
    input  logic [7:0] byte_data,
    output logic       is_op,
    output logic [2:0] opcode
);

    always_comb begin
        is_op  = 1'b1;
        opcode = OP_HALT;
        case (byte_data)
            CH_INC:   opcode = OP_INC;
            CH_DEC:   opcode = OP_DEC;
            CH_RIGHT: opcode = OP_RIGHT;
            CH_LEFT:  opcode = OP_LEFT;
            CH_OPEN:  opcode = OP_OPEN;
            CH_CLOSE: opcode = OP_CLOSE;
            default:  is_op  = 1'b0;
        endcase
    end

endmodule

// File: rtl/bf_prog_loader.sv
// bf_prog_loader: filters a Brainfuck source byte stream, writes encoded
// opcodes sequentially into program memory, checks bracket balance and
// releases the core reset once a well-formed program is terminated.
//
// Ports:
//   i_clock, i_reset           clock, synchronous active-high reset
//   i_byte_data/valid          source byte stream
//   o_byte_ready               high while loading (1 byte/cycle)
//   o_prgmem_we/addr/data      program memory write port (one-cycle pulses)
//   o_core_reset               held high until the load completes
//   o_done / o_error           sticky completion / abort flags
//   o_error_code               abort cause (bf_pkg ERR_*)
//   o_length                   opcodes written, HALT excluded
//
// state | meaning
// ------+-----------------------------------------------------------
// LOAD  | accepting bytes, writing opcodes, tracking bracket depth
// TERM  | HALT write pulse is on the bus this cycle
// DONE  | program loaded, core released, input ignored until reset
// ERR   | load aborted, cause held on o_error_code
module bf_prog_loader
    import bf_pkg::*;
#(
    parameter int         PRG_ADDR_W  = 8,
    parameter int         INSTR_W     = 3,
    parameter int         MAX_DEPTH_W = 4,
    parameter logic [7:0] END_CHAR    = 8'h21
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [7:0]            i_byte_data,
    input  logic                  i_byte_valid,
    output logic                  o_byte_ready,
    output logic                  o_prgmem_we,
    output logic [PRG_ADDR_W-1:0] o_prgmem_addr,
    output logic [INSTR_W-1:0]    o_prgmem_data,
    output logic                  o_core_reset,
    output logic                  o_done,
    output logic                  o_error,
    output logic [2:0]            o_error_code,
    output logic [PRG_ADDR_W-1:0] o_length
);

    logic [1:0]             state;
    logic [PRG_ADDR_W-1:0]  wr_ptr;
    logic [MAX_DEPTH_W-1:0] depth;
    logic [2:0]             err_code;
    logic                   enc_is_op;
    logic [2:0]             enc_op;
    logic                   accept;
    logic                   ptr_full;
    logic                   depth_full;
    logic                   depth_zero;

    bf_char_encoder u_enc (
        .byte_data (i_byte_data),
        .is_op     (enc_is_op),
        .opcode    (enc_op)
    );

    assign o_byte_ready = (state == ST_LOAD);
    assign accept       = o_byte_ready && i_byte_valid;

    // The last memory slot is kept free so a HALT always fits.
    assign ptr_full   = (wr_ptr == {PRG_ADDR_W{1'b1}});
    assign depth_full = (depth == {MAX_DEPTH_W{1'b1}});
    assign depth_zero = (depth == '0);

    assign o_done       = (state == ST_DONE);
    assign o_error      = (state == ST_ERR);
    assign o_core_reset = (state != ST_DONE);
    assign o_error_code = err_code;
    // Every successful opcode write advances wr_ptr, so it is the length.
    assign o_length     = wr_ptr;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state         <= ST_LOAD;
            wr_ptr        <= '0;
            depth         <= '0;
            err_code      <= ERR_NONE;
            o_prgmem_we   <= 1'b0;
            o_prgmem_addr <= '0;
            o_prgmem_data <= '0;
        end else begin
            o_prgmem_we <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        if (enc_is_op) begin
                            if (enc_op == OP_CLOSE && depth_zero) begin
                                err_code <= ERR_UNMATCHED;
                                state    <= ST_ERR;
                            end else if (enc_op == OP_OPEN && depth_full) begin
                                err_code <= ERR_DEPTH;
                                state    <= ST_ERR;
                            end else if (ptr_full) begin
                                err_code <= ERR_LENGTH;
                                state    <= ST_ERR;
                            end else begin
                                o_prgmem_we   <= 1'b1;
                                o_prgmem_addr <= wr_ptr;
                                o_prgmem_data <= INSTR_W'(enc_op);
                                wr_ptr        <= wr_ptr + PRG_ADDR_W'(1);
                                if (enc_op == OP_OPEN)
                                    depth <= depth + MAX_DEPTH_W'(1);
                                else if (enc_op == OP_CLOSE)
                                    depth <= depth - MAX_DEPTH_W'(1);
                            end
                        end else if (i_byte_data == END_CHAR) begin
                            if (!depth_zero) begin
                                err_code <= ERR_UNCLOSED;
                                state    <= ST_ERR;
                            end else begin
                                // HALT pulse appears during TERM; wr_ptr stays
                                // put so o_length excludes the terminator.
                                o_prgmem_we   <= 1'b1;
                                o_prgmem_addr <= wr_ptr;
                                o_prgmem_data <= INSTR_W'(OP_HALT);
                                state         <= ST_TERM;
                            end
                        end
                    end
                end
                ST_TERM: state <= ST_DONE;
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_bf_prog_loader.sv
module tb_bf_prog_loader;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_byte_data;
    logic       i_byte_valid;
    logic       o_byte_ready;
    logic       o_prgmem_we;
    logic [7:0] o_prgmem_addr;
    logic [2:0] o_prgmem_data;
    logic       o_core_reset;
    logic       o_done;
    logic       o_error;
    logic [2:0] o_error_code;
    logic [7:0] o_length;

    int errors = 0;
    int checks = 0;

    logic [7:0] obs_addr[$];
    logic [2:0] obs_data[$];
    int cyc = 0;
    int halt_cyc = -1;
    int done_cyc = -1;
    int crst_cyc = -1;
    int bad_we = 0;

    logic [2:0] exp_q[$];
    int exp_len;
    bit exp_done;
    bit exp_err;
    int exp_code;

    bf_prog_loader dut (
        .i_clock       (clk),
        .i_reset       (i_reset),
        .i_byte_data   (i_byte_data),
        .i_byte_valid  (i_byte_valid),
        .o_byte_ready  (o_byte_ready),
        .o_prgmem_we   (o_prgmem_we),
        .o_prgmem_addr (o_prgmem_addr),
        .o_prgmem_data (o_prgmem_data),
        .o_core_reset  (o_core_reset),
        .o_done        (o_done),
        .o_error       (o_error),
        .o_error_code  (o_error_code),
        .o_length      (o_length)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (o_prgmem_we) begin
            obs_addr.push_back(o_prgmem_addr);
            obs_data.push_back(o_prgmem_data);
            if (o_prgmem_data == 3'd0 && halt_cyc < 0) halt_cyc = cyc;
            if (o_done || o_error) bad_we = bad_we + 1;
        end
        if (o_done && done_cyc < 0) done_cyc = cyc;
        if (!o_core_reset && crst_cyc < 0) crst_cyc = cyc;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: opcode of an ASCII character, -1 if it is filtered out.
    function automatic int ref_op(input logic [7:0] c);
        case (c)
            8'h2B:   return 3;
            8'h2D:   return 2;
            8'h3E:   return 5;
            8'h3C:   return 4;
            8'h5B:   return 7;
            8'h5D:   return 6;
            default: return -1;
        endcase
    endfunction

    // Reference model: walks the source text and predicts the memory image
    // plus final status, stopping at the first terminating event.
    function automatic void model(input bq_t s);
        int depth;
        bit stop;
        int op;
        depth = 0; stop = 0;
        exp_q = {}; exp_done = 0; exp_err = 0; exp_code = 0;
        for (int i = 0; i < s.size() && !stop; i++) begin
            op = ref_op(s[i]);
            if (op >= 0) begin
                if (op == 6 && depth == 0) begin
                    exp_err = 1; exp_code = 1; stop = 1;
                end else if (op == 7 && depth == 15) begin
                    exp_err = 1; exp_code = 2; stop = 1;
                end else if (exp_q.size() == 255) begin
                    exp_err = 1; exp_code = 3; stop = 1;
                end else begin
                    exp_q.push_back(3'(op));
                    if (op == 7) depth++;
                    if (op == 6) depth--;
                end
            end else if (s[i] == 8'h21) begin
                if (depth != 0) begin
                    exp_err = 1; exp_code = 4;
                end else begin
                    exp_done = 1;
                end
                stop = 1;
            end
        end
        exp_len = exp_q.size();
        if (exp_done) exp_q.push_back(3'd0);
    endfunction

    function automatic bq_t str2q(input string str);
        bq_t q;
        q = {};
        for (int i = 0; i < str.len(); i++) q.push_back(str[i]);
        return q;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        i_reset = 1'b1;
        i_byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        obs_addr = {}; obs_data = {};
        halt_cyc = -1; done_cyc = -1; crst_cyc = -1; bad_we = 0;
    endtask

    // Presents the stream, optionally with idle gaps, stops once the loader
    // drops ready, then keeps pushing opcode bytes to show they are ignored.
    task automatic run_stream(input bq_t s, input int gap_pct);
        int i;
        int guard;
        i = 0; guard = 0;
        while (i < s.size() && guard < 4000) begin
            @(negedge clk);
            guard++;
            if (!o_byte_ready) break;
            if ($urandom_range(0, 99) < gap_pct) begin
                i_byte_valid = 1'b0;
            end else begin
                i_byte_data  = s[i];
                i_byte_valid = 1'b1;
                i++;
            end
        end
        repeat (3) begin
            @(negedge clk);
            i_byte_data  = 8'h2B;
            i_byte_valid = 1'b1;
        end
        @(negedge clk);
        i_byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_byte_valid = 1'b1;
        i_byte_data = 8'h2B;
        repeat (3) @(negedge clk);
        checks++; if (o_prgmem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %0b want 0", o_prgmem_we); end
        checks++; if (o_prgmem_addr !== 8'd0) begin errors++; $display("FAIL rst_addr: got %0d want 0", o_prgmem_addr); end
        checks++; if (o_prgmem_data !== 3'd0) begin errors++; $display("FAIL rst_data: got %0d want 0", o_prgmem_data); end
        checks++; if (o_core_reset !== 1'b1) begin errors++; $display("FAIL rst_core_reset: got %0b want 1", o_core_reset); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b want 0", o_done); end
        checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL rst_error: got %0b want 0", o_error); end
        checks++; if (o_error_code !== 3'd0) begin errors++; $display("FAIL rst_code: got %0d want 0", o_error_code); end
        checks++; if (o_length !== 8'd0) begin errors++; $display("FAIL rst_length: got %0d want 0", o_length); end
        checks++; if (o_byte_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b want 1", o_byte_ready); end
        i_reset = 1'b0;
        i_byte_valid = 1'b0;
    endtask

    // Directed streams from the plan followed by random streams.
    task automatic test_streams();
        string fixed[$];
        string alpha;
        string nm;
        string sl;
        bq_t s;
        int nrand;
        fixed = '{"+[->+<]!", "a+ \n-.!", "]", "[[+]!", "!", "[]]>!", "+\r\n,<>[.]!"};
        sl = "";
        for (int k = 0; k < 16; k++) sl = {sl, "["};
        fixed.push_back(sl);
        alpha = "+++--<>[[]]. ,x\n";
        nrand = 30;
        for (int t = 0; t < fixed.size() + nrand; t++) begin
            s = {};
            if (t < fixed.size()) begin
                s = str2q(fixed[t]);
                nm = $sformatf("fixed%0d", t);
            end else begin
                for (int k = 0; k < $urandom_range(0, 40); k++)
                    s.push_back(alpha[$urandom_range(0, alpha.len() - 1)]);
                s.push_back(8'h21);
                nm = $sformatf("rand%0d", t - fixed.size());
            end
            do_reset();
            model(s);
            run_stream(s, (t < fixed.size()) ? 0 : 30);
            checks++;
            if (obs_data.size() != exp_q.size()) begin
                errors++;
                $display("FAIL %s nwrites: got %0d want %0d", nm, obs_data.size(), exp_q.size());
            end
            for (int k = 0; k < exp_q.size() && k < obs_data.size(); k++) begin
                checks++;
                if (obs_addr[k] !== 8'(k) || obs_data[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL %s write%0d: got %0d@%0d want %0d@%0d", nm, k, obs_data[k], obs_addr[k], exp_q[k], k);
                end
            end
            checks++; if (o_done !== exp_done) begin errors++; $display("FAIL %s done: got %0b want %0b", nm, o_done, exp_done); end
            checks++; if (o_error !== exp_err) begin errors++; $display("FAIL %s error: got %0b want %0b", nm, o_error, exp_err); end
            checks++; if (o_error_code !== 3'(exp_code)) begin errors++; $display("FAIL %s code: got %0d want %0d", nm, o_error_code, exp_code); end
            checks++; if (o_length !== 8'(exp_len)) begin errors++; $display("FAIL %s length: got %0d want %0d", nm, o_length, exp_len); end
            checks++; if (o_core_reset !== !exp_done) begin errors++; $display("FAIL %s core_reset: got %0b want %0b", nm, o_core_reset, !exp_done); end
            checks++; if (o_byte_ready !== 1'b0) begin errors++; $display("FAIL %s ready: got %0b want 0", nm, o_byte_ready); end
            checks++; if (bad_we != 0) begin errors++; $display("FAIL %s we_in_final: got %0d want 0", nm, bad_we); end
            if (exp_done) begin
                checks++; if (done_cyc != halt_cyc + 1) begin errors++; $display("FAIL %s done_timing: got %0d want %0d", nm, done_cyc, halt_cyc + 1); end
                checks++; if (crst_cyc != done_cyc) begin errors++; $display("FAIL %s core_release: got %0d want %0d", nm, crst_cyc, done_cyc); end
            end else begin
                checks++; if (crst_cyc != -1) begin errors++; $display("FAIL %s core_release: got %0d want -1", nm, crst_cyc); end
            end
        end
    endtask

    // 255 opcodes fill every slot but the last; the next byte decides.
    task automatic test_capacity();
        bq_t s;
        string nm;
        for (int v = 0; v < 2; v++) begin
            s = {};
            for (int k = 0; k < 255; k++) s.push_back(8'h2B);
            s.push_back(v == 0 ? 8'h2B : 8'h21);
            nm = (v == 0) ? "cap_overflow" : "cap_full";
            do_reset();
            model(s);
            run_stream(s, 0);
            checks++;
            if (obs_data.size() != exp_q.size()) begin
                errors++;
                $display("FAIL %s nwrites: got %0d want %0d", nm, obs_data.size(), exp_q.size());
            end
            for (int k = 0; k < exp_q.size() && k < obs_data.size(); k++) begin
                checks++;
                if (obs_addr[k] !== 8'(k) || obs_data[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL %s write%0d: got %0d@%0d want %0d@%0d", nm, k, obs_data[k], obs_addr[k], exp_q[k], k);
                end
            end
            checks++; if (o_done !== exp_done) begin errors++; $display("FAIL %s done: got %0b want %0b", nm, o_done, exp_done); end
            checks++; if (o_error !== exp_err) begin errors++; $display("FAIL %s error: got %0b want %0b", nm, o_error, exp_err); end
            checks++; if (o_error_code !== 3'(exp_code)) begin errors++; $display("FAIL %s code: got %0d want %0d", nm, o_error_code, exp_code); end
            checks++; if (o_length !== 8'(exp_len)) begin errors++; $display("FAIL %s length: got %0d want %0d", nm, o_length, exp_len); end
            checks++; if (o_core_reset !== !exp_done) begin errors++; $display("FAIL %s core_reset: got %0b want %0b", nm, o_core_reset, !exp_done); end
        end
    endtask

    task automatic test_midload_reset();
        bq_t s;
        do_reset();
        s = str2q("+-+");
        for (int k = 0; k < s.size(); k++) begin
            @(negedge clk);
            i_byte_data = s[k];
            i_byte_valid = 1'b1;
        end
        @(negedge clk);
        i_reset = 1'b1;
        i_byte_data = 8'h3E;
        i_byte_valid = 1'b1;
        @(negedge clk);
        checks++; if (obs_data.size() != 3) begin errors++; $display("FAIL mid_prewrites: got %0d want 3", obs_data.size()); end
        checks++; if (o_prgmem_we !== 1'b0) begin errors++; $display("FAIL mid_we: got %0b want 0", o_prgmem_we); end
        checks++; if (o_prgmem_addr !== 8'd0) begin errors++; $display("FAIL mid_addr: got %0d want 0", o_prgmem_addr); end
        checks++; if (o_prgmem_data !== 3'd0) begin errors++; $display("FAIL mid_data: got %0d want 0", o_prgmem_data); end
        checks++; if (o_length !== 8'd0) begin errors++; $display("FAIL mid_length: got %0d want 0", o_length); end
        checks++; if (o_core_reset !== 1'b1 || o_done !== 1'b0 || o_error !== 1'b0) begin
            errors++; $display("FAIL mid_status: got crst=%0b done=%0b err=%0b want 1 0 0", o_core_reset, o_done, o_error);
        end
        checks++; if (o_byte_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %0b want 1", o_byte_ready); end
        i_reset = 1'b0;
        i_byte_valid = 1'b0;
        obs_addr = {}; obs_data = {};
        s = str2q("-!");
        model(s);
        run_stream(s, 0);
        checks++;
        if (obs_data.size() != exp_q.size()) begin
            errors++;
            $display("FAIL reload nwrites: got %0d want %0d", obs_data.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < obs_data.size(); k++) begin
            checks++;
            if (obs_addr[k] !== 8'(k) || obs_data[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL reload write%0d: got %0d@%0d want %0d@%0d", k, obs_data[k], obs_addr[k], exp_q[k], k);
            end
        end
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL reload done: got %0b want 1", o_done); end
        checks++; if (o_length !== 8'd1) begin errors++; $display("FAIL reload length: got %0d want 1", o_length); end
    endtask

    initial begin
        i_reset = 1'b1;
        i_byte_valid = 1'b0;
        i_byte_data = 8'h00;
        test_reset();
        test_streams();
        test_capacity();
        test_midload_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
